vr_log_ptr_mgr: RTL
===================

// Module: vr_log_ptr_mgr
// PURPOSE
//  Parametrised allocator for the VR replica log. It owns the head/tail pointers of the
//  header log and the data log, and the first_log_op/last_op counters. It hands out slots
//  for incoming Prepare entries (per-entry line cost = ceil(len/DATA_W_BYTES)). It frees
//  entries from the head on clean_up_to, and flushes the log on a view change.
//  Sits between the Prepare handler and the log RAM writers; its outputs feed vr_state.
// PARAMETERS
//  HDR_DEPTH     2048  header-log entries (power of 2); HDR_W = $clog2(HDR_DEPTH)
//  DATA_DEPTH    2048  data-log lines (power of 2); DATA_W = $clog2(DATA_DEPTH)
//  DATA_W_BYTES  64    bytes per data-log line (power of 2)
//  OP_W          64    op-number width
//  LEN_W         64    payload-length width
// PORTS
//  clk               in   1         clock
//  rst               in   1         asynchronous, active-high reset
//  alloc_val         in   1         request a log slot
//  alloc_op_num      in   OP_W      op number of new entry
//  alloc_len_bytes   in   LEN_W     payload bytes of new entry
//  alloc_rdy         out  1         accept alloc (FSM IDLE)
//  alloc_resp_val    out  1         allocation result valid
//  alloc_resp_ok     out  1         1=slot granted, 0=rejected (full/out-of-order)
//  alloc_hdr_addr    out  HDR_W     granted header-log index
//  alloc_data_addr   out  DATA_W    granted first data-log line
//  alloc_resp_rdy    in   1         consumer takes result
//  clean_val         in   1         free entries with op < clean_up_to
//  clean_up_to       in   OP_W      clean bound (exclusive)
//  clean_rdy         out  1         accept clean (FSM IDLE, no alloc_val)
//  flush_val         in   1         view-change flush: empty log, restart op numbering
//  flush_next_op     in   OP_W      op number expected next after flush
//  hdr_log_head      out  HDR_W+1   header head pointer (with wrap bit)
//  hdr_log_tail      out  HDR_W+1   header tail pointer (with wrap bit)
//  data_log_head     out  DATA_W+1  data head pointer (with wrap bit)
//  data_log_tail     out  DATA_W+1  data tail pointer (with wrap bit)
//  first_log_op      out  OP_W      op number at header head
//  last_op           out  OP_W      last allocated op number
//  busy              out  1         FSM not IDLE
// BEHAVIOUR
//  Reset: all pointers 0, first_log_op=1, last_op=0, alloc_resp_val=0, FSM=IDLE.
//   rdy outputs are 1 once reset deasserts.
//  Pointers: addr = low bits; empty when ptr equal; full when MSBs differ and low bits
//   are equal. Used count = tail-head mod 2^(W+1). Data entries may straddle the wrap.
//  FSM states: IDLE, ALLOC_RESP, CLEAN_RD, CLEAN_UPD.
//  Priority in IDLE: flush > alloc > clean. clean_rdy=0 whenever alloc_val=1.
//  Alloc: the handshake in IDLE registers the request.
//   - Next cycle: ALLOC_RESP with alloc_resp_val=1, held until alloc_resp_rdy.
//   - lines = ceil(alloc_len_bytes/DATA_W_BYTES). len=0 still consumes a header entry.
//   - ok = hdr not full && lines <= DATA_DEPTH-data_used && alloc_op_num==last_op+1.
//   - If ok, in the accept cycle: hdr_addr=hdr tail, data_addr=data tail; the entry's line
//     count is written to the internal HDR_DEPTH-entry RAM; hdr_tail+=1; data_tail+=lines;
//     last_op=alloc_op_num.
//   - Reject leaves all state unchanged. Return to IDLE on the response handshake.
//  Clean: accept latches clean_up_to and enters CLEAN_RD.
//   - CLEAN_RD: if hdr empty or first_log_op >= bound, go to IDLE. Otherwise issue a
//     synchronous read of the line count at the hdr head and go to CLEAN_UPD.
//   - CLEAN_UPD: data_head += count, hdr_head += 1, first_log_op += 1, go to CLEAN_RD.
//   - Cost: 2 cycles per freed entry plus 1 terminating cycle.
//  Flush: accepted in any state. It wins over everything in the same cycle.
//   - head=tail for both logs; first_log_op=flush_next_op; last_op=flush_next_op-1.
//   - An in-flight clean is aborted, then IDLE.
//   - A pending alloc response is still delivered with ok=0, then IDLE.
//  Arithmetic: pointer adds wrap at 2^(W+1). Op counters wrap at 2^OP_W (no saturation).
//  busy = (FSM != IDLE).
// TESTING
//  1. Reset, alloc op=1 len=100 -> resp_ok=1, hdr_addr=0, data_addr=0,
//     data_tail=2, hdr_tail=1, last_op=1.
//  2. Alloc op=3 after op=1 -> resp_ok=0, pointers unchanged. Hold alloc_resp_rdy=0 for
//     5 cycles -> resp_val stays 1 and alloc_rdy stays 0.
//  3. Fill HDR_DEPTH entries of len 0 -> next alloc ok=0, hdr_log_head=0, hdr_log_tail=
//     HDR_DEPTH. Clean to op 3 -> head=2, first_log_op=3, busy for 5 cycles.
//  4. Data wrap: DATA_DEPTH=16, allocs of 6,6 lines, clean 1, alloc 6 -> data_addr=12,
//     data_tail=18. Alloc of 5 lines then rejected (4 free).
//  5. Flush with next_op=50 during CLEAN_UPD -> head=tail, first_log_op=50, last_op=49;
//     next alloc op=50 ok.
//  6. Assert rst mid-ALLOC_RESP -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/vr_log_ptr_mgr.sv
// vr_log_ptr_mgr: head/tail allocator for the VR replica header log and data log.
//
// Hands out one header slot plus ceil(len/DATA_W_BYTES) data lines for each Prepare
// entry. Frees entries from the header head on a clean request, and empties the log
// on a view-change flush.
//
// Ports
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_alloc_*/o_alloc_rdy            allocation request (op number, payload length)
//   o_alloc_resp_*/i_alloc_resp_rdy  allocation result (ok flag, header index, first line)
//   i_clean_*/o_clean_rdy            free every entry whose op is below i_clean_up_to
//   i_flush_val, i_flush_next_op     empty both logs and restart op numbering
//   o_hdr_log_*/o_data_log_*         head/tail pointers, one extra MSB as the wrap bit
//   o_first_log_op, o_last_op        op number at the header head / last granted op
//   o_busy                           controller is not idle
//
// state        | meaning
// S_IDLE       | accepting flush, alloc or clean (in that priority)
// S_ALLOC_RESP | holding the allocation result until the consumer takes it
// S_CLEAN_RD   | testing the head entry against the bound, reading its line count
// S_CLEAN_UPD  | retiring the head entry using the line count just read
module vr_log_ptr_mgr #(
    parameter int HDR_DEPTH    = 2048,
    parameter int DATA_DEPTH   = 2048,
    parameter int DATA_W_BYTES = 64,
    parameter int OP_W         = 64,
    parameter int LEN_W        = 64,
    localparam int HDR_W       = $clog2(HDR_DEPTH),
    localparam int DATA_W      = $clog2(DATA_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_alloc_val,
    input  logic [OP_W-1:0]   i_alloc_op_num,
    input  logic [LEN_W-1:0]  i_alloc_len_bytes,
    output logic              o_alloc_rdy,
    output logic              o_alloc_resp_val,
    output logic              o_alloc_resp_ok,
    output logic [HDR_W-1:0]  o_alloc_hdr_addr,
    output logic [DATA_W-1:0] o_alloc_data_addr,
    input  logic              i_alloc_resp_rdy,
    input  logic              i_clean_val,
    input  logic [OP_W-1:0]   i_clean_up_to,
    output logic              o_clean_rdy,
    input  logic              i_flush_val,
    input  logic [OP_W-1:0]   i_flush_next_op,
    output logic [HDR_W:0]    o_hdr_log_head,
    output logic [HDR_W:0]    o_hdr_log_tail,
    output logic [DATA_W:0]   o_data_log_head,
    output logic [DATA_W:0]   o_data_log_tail,
    output logic [OP_W-1:0]   o_first_log_op,
    output logic [OP_W-1:0]   o_last_op,
    output logic              o_busy
);

    localparam int              BYTE_SH    = $clog2(DATA_W_BYTES);
    localparam logic [DATA_W:0] DATA_CAP   = DATA_DEPTH[DATA_W:0];

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ALLOC_RESP = 2'd1,
        S_CLEAN_RD   = 2'd2,
        S_CLEAN_UPD  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [HDR_W:0]    r_hdr_head;
    logic [HDR_W:0]    r_hdr_tail;
    logic [DATA_W:0]   r_data_head;
    logic [DATA_W:0]   r_data_tail;
    logic [OP_W-1:0]   r_first_log_op;
    logic [OP_W-1:0]   r_last_op;
    logic [OP_W-1:0]   r_clean_bound;
    logic              r_resp_ok;
    logic [HDR_W-1:0]  r_resp_hdr_addr;
    logic [DATA_W-1:0] r_resp_data_addr;

    // Per-entry line count, indexed by header slot; read back when the entry is freed.
    logic [DATA_W:0]   r_ram [HDR_DEPTH];
    logic [DATA_W:0]   r_rd_count;

    logic              w_hdr_empty;
    logic              w_hdr_full;
    logic [DATA_W:0]   w_data_used;
    logic [DATA_W:0]   w_data_free;
    logic [LEN_W-1:0]  w_len_rem;
    logic [LEN_W-1:0]  w_lines;
    logic              w_alloc_ok;
    logic              w_alloc_fire;
    logic              w_clean_fire;
    logic              w_clean_done;

    assign w_hdr_empty = (r_hdr_head == r_hdr_tail);
    assign w_hdr_full  = (r_hdr_head[HDR_W] != r_hdr_tail[HDR_W]) &&
                         (r_hdr_head[HDR_W-1:0] == r_hdr_tail[HDR_W-1:0]);
    assign w_data_used = r_data_tail - r_data_head;
    assign w_data_free = DATA_CAP - w_data_used;

    // Ceiling divide written as shift plus remainder test so it cannot overflow at max length.
    assign w_len_rem   = i_alloc_len_bytes & LEN_W'(DATA_W_BYTES - 1);
    assign w_lines     = (i_alloc_len_bytes >> BYTE_SH) + LEN_W'(w_len_rem != '0);

    assign w_alloc_ok  = !w_hdr_full &&
                         (w_lines <= LEN_W'(w_data_free)) &&
                         (i_alloc_op_num == r_last_op + OP_W'(1));

    // Flush takes priority, so neither handshake can complete while it is asserted.
    assign o_alloc_rdy = (r_state == S_IDLE) && !i_rst && !i_flush_val;
    assign o_clean_rdy = (r_state == S_IDLE) && !i_rst && !i_flush_val && !i_alloc_val;

    assign w_alloc_fire = o_alloc_rdy && i_alloc_val;
    assign w_clean_fire = o_clean_rdy && i_clean_val;
    assign w_clean_done = w_hdr_empty || (r_first_log_op >= r_clean_bound);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_alloc_fire) begin
                    w_state_nxt = S_ALLOC_RESP;
                end else if (w_clean_fire) begin
                    w_state_nxt = S_CLEAN_RD;
                end
            end
            // A flush here only clears the ok flag; the response is still delivered.
            S_ALLOC_RESP: begin
                if (i_alloc_resp_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAN_RD: begin
                if (i_flush_val || w_clean_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CLEAN_UPD;
                end
            end
            S_CLEAN_UPD: begin
                w_state_nxt = i_flush_val ? S_IDLE : S_CLEAN_RD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hdr_head       <= '0;
            r_hdr_tail       <= '0;
            r_data_head      <= '0;
            r_data_tail      <= '0;
            r_first_log_op   <= OP_W'(1);
            r_last_op        <= '0;
            r_clean_bound    <= '0;
            r_resp_ok        <= 1'b0;
            r_resp_hdr_addr  <= '0;
            r_resp_data_addr <= '0;
        end else if (i_flush_val) begin
            r_hdr_head     <= r_hdr_tail;
            r_data_head    <= r_data_tail;
            r_first_log_op <= i_flush_next_op;
            r_last_op      <= i_flush_next_op - OP_W'(1);
            r_resp_ok      <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                r_resp_ok        <= w_alloc_ok;
                r_resp_hdr_addr  <= r_hdr_tail[HDR_W-1:0];
                r_resp_data_addr <= r_data_tail[DATA_W-1:0];
                if (w_alloc_ok) begin
                    r_hdr_tail  <= r_hdr_tail + 1'b1;
                    r_data_tail <= r_data_tail + w_lines[DATA_W:0];
                    r_last_op   <= i_alloc_op_num;
                end
            end
            if (w_clean_fire) begin
                r_clean_bound <= i_clean_up_to;
            end
            if (r_state == S_CLEAN_UPD) begin
                r_data_head    <= r_data_head + r_rd_count;
                r_hdr_head     <= r_hdr_head + 1'b1;
                r_first_log_op <= r_first_log_op + OP_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_alloc_fire && w_alloc_ok) begin
            r_ram[r_hdr_tail[HDR_W-1:0]] <= w_lines[DATA_W:0];
        end
        if (r_state == S_CLEAN_RD) begin
            r_rd_count <= r_ram[r_hdr_head[HDR_W-1:0]];
        end
    end

    assign o_alloc_resp_val  = (r_state == S_ALLOC_RESP);
    assign o_alloc_resp_ok   = r_resp_ok;
    assign o_alloc_hdr_addr  = r_resp_hdr_addr;
    assign o_alloc_data_addr = r_resp_data_addr;
    assign o_hdr_log_head    = r_hdr_head;
    assign o_hdr_log_tail    = r_hdr_tail;
    assign o_data_log_head   = r_data_head;
    assign o_data_log_tail   = r_data_tail;
    assign o_first_log_op    = r_first_log_op;
    assign o_last_op         = r_last_op;
    assign o_busy            = (r_state != S_IDLE);

endmodule
